// File: rtl/serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// serial_frame_receiver
//
// Receive end of the serial shift link. It turns a framed bit stream into
// parallel words. Each frame is one start bit (0), WIDTH data bits, an optional
// even-parity bit, and one stop bit (1). Each word goes to a one-deep
// valid/ready output buffer.
//
// Optional feature macro: SER_RX_PARITY_EN
//   defined   : the PARITY state is present and parity_err is live.
//   undefined : there is no parity bit in the frame and parity_err is tied 0.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears all state
//   sin         serial line bit, sampled only when sin_valid=1
//   sin_valid   bit strobe; the FSM only advances on strobed cycles
//   lsb_first   1: first data bit is word bit 0; 0: first data bit is the MSB.
//               Latched at the start bit.
//   dout        received word, stable while dout_valid=1
//   dout_valid  word available; held until accepted
//   dout_ready  consumer accepts dout when dout_valid & dout_ready
//   busy        1 while a frame is in progress (not IDLE)
//   frame_err   1-cycle pulse: stop bit sampled as 0
//   parity_err  1-cycle pulse: parity mismatch
//   overrun     1-cycle pulse: good frame arrived while the buffer was full
//               and not being drained
// -----------------------------------------------------------------------------
module serial_frame_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef SER_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2, PARITY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_nxt;
  logic [CW-1:0]    cnt_q;
  logic             lsb_q;      // bit order frozen for the whole frame
  logic             par_bad;    // parity mismatch recorded for this frame

  // One-cycle event strobes decoded from the FSM.
  logic start_ev, shift_ev, stop_ev;
  logic commit, accept, full_hold;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_ev = 1'b0;
    shift_ev = 1'b0;
    stop_ev  = 1'b0;
    if (sin_valid) begin
      case (state_q)
        IDLE: if (!sin) begin
          state_d  = DATA;
          start_ev = 1'b1;
        end
        DATA: begin
          shift_ev = 1'b1;
          if (cnt_q == LAST) begin
`ifdef SER_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef SER_RX_PARITY_EN
        PARITY: state_d = STOP;
`endif
        STOP: begin
          stop_ev = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------- datapath
  assign shreg_nxt = lsb_q ? {sin, shreg_q[WIDTH-1:1]}
                           : {shreg_q[WIDTH-2:0], sin};

  // A good frame commits only when the stop bit is 1 and there is no parity
  // mismatch. A full buffer that is not being drained keeps the old word.
  assign commit    = stop_ev & sin & ~par_bad;
  assign accept    = dout_valid & dout_ready;
  assign full_hold = dout_valid & ~dout_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q    <= '0;
      cnt_q      <= '0;
      lsb_q      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_ev & ~sin;
      overrun   <= commit & full_hold;
      if (start_ev) begin
        cnt_q <= '0;
        lsb_q <= lsb_first;
      end
      if (shift_ev) begin
        shreg_q <= shreg_nxt;
        cnt_q   <= cnt_q + 1'b1;
      end
      if (commit && !full_hold) begin
        dout       <= shreg_q;
        dout_valid <= 1'b1;
      end else if (accept) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef SER_RX_PARITY_EN
  // Even parity: the parity bit must equal the XOR of the data bits. Sampling
  // happens in PARITY, and the verdict is given at STOP. A bad stop bit
  // (frame_err) takes priority over a parity error.
  logic par_bad_q;
  assign par_bad = par_bad_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= stop_ev & sin & par_bad_q;
      if (start_ev)
        par_bad_q <= 1'b0;
      else if (sin_valid && state_q == PARITY)
        par_bad_q <= sin ^ (^shreg_q);
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_receiver
//
// Bench for serial_frame_receiver (WIDTH=4). Each frame is built from a word,
// a bit order, a stop bit and a parity choice. The bench keeps a frame-level
// model of the one-deep output buffer. Outputs are checked 1 time unit after
// every rising edge.
// -----------------------------------------------------------------------------
module tb_serial_frame_receiver;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset, sin, sin_valid, lsb_first, dout_ready;
  logic [W-1:0] dout;
  logic dout_valid, busy, frame_err, parity_err, overrun;

  serial_frame_receiver #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
    .lsb_first(lsb_first), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [W-1:0] m_dout;
  bit m_valid, m_busy;
  int stall_pct = 0;  // >=100 means exactly one stall cycle before each bit
  int rdy_mode  = 1;  // 0: ready low, 1: ready high, 2: random

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. The expected frame-level events for this edge are
  // supplied by the caller. The model updates the buffer and then checks the
  // DUT outputs.
  task automatic tick(input bit commit, input bit ferr, input bit perr,
                      input bit busy_after, input logic [W-1:0] word, input int rdy);
    bit e_ovr;
    e_ovr = 0;
    dout_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : (rdy == 1);
    if (commit) begin
      if (m_valid && !dout_ready) e_ovr = 1;
      else begin m_dout = word; m_valid = 1; end
    end else if (m_valid && dout_ready) begin
      m_valid = 0;
    end
    m_busy = busy_after;
    @(posedge clk); #1;
    chk("dout_valid", dout_valid, m_valid);
    if (m_valid) chk("dout", dout, m_dout);
    chk("frame_err", frame_err, ferr);
    chk("parity_err", parity_err, perr);
    chk("overrun", overrun, e_ovr);
    chk("busy", busy, busy_after);
  endtask

  task automatic stall();
    int n;
    n = (stall_pct >= 100) ? 1 : 0;
    while (n < 3 && stall_pct < 100 && $urandom_range(0, 99) < stall_pct) n++;
    repeat (n) begin
      sin_valid = 0;
      sin = 1'($urandom_range(0, 1));
      tick(0, 0, 0, m_busy, '0, rdy_mode);
    end
  endtask

  task automatic bit_out(input logic b, input bit commit, input bit ferr, input bit perr,
                         input bit busy_after, input logic [W-1:0] word, input int rdy);
    stall();
    sin_valid = 1;
    sin = b;
    tick(commit, ferr, perr, busy_after, word, rdy);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) bit_out(1'b1, 0, 0, 0, 0, '0, rdy_mode);
  endtask

  task automatic send_frame(input logic [W-1:0] word, input bit lsb, input bit stop_b,
                            input bit pflip, input bit toggle, input int stop_rdy);
    bit pbad;
    pbad = 0;
    lsb_first = lsb;
    bit_out(1'b0, 0, 0, 0, 1, word, rdy_mode);
    if (toggle) lsb_first = ~lsb;
    for (int i = 0; i < W; i++)
      bit_out(lsb ? word[i] : word[W-1-i], 0, 0, 0, 1, word, rdy_mode);
`ifdef SER_RX_PARITY_EN
    pbad = pflip;
    bit_out((^word) ^ pflip, 0, 0, 0, 1, word, rdy_mode);
`endif
    bit_out(stop_b, stop_b && !pbad, !stop_b, stop_b && pbad, 0, word, stop_rdy);
    lsb_first = lsb;
  endtask

  initial begin
    reset = 1; sin = 1; sin_valid = 0; lsb_first = 0; dout_ready = 1;
    m_dout = '0; m_valid = 0; m_busy = 0;
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk); #1 reset = 0;

    // The line is idle, then an msb-first frame arrives.
    idle_bits(2);
    send_frame(4'b1011, 0, 1, 0, 0, 1);
    idle_bits(1);
    // An lsb-first frame arrives, with lsb_first toggled mid-frame.
    send_frame(4'b0011, 1, 1, 0, 1, 1);
    // The stop bit is 0, then the next frame is back-to-back.
    send_frame(4'hF, 0, 0, 0, 0, 1);
    send_frame(4'h6, 0, 1, 0, 0, 1);
    idle_bits(1);
    // Back-pressure, with overrun, then a drain on the commit cycle.
    rdy_mode = 0;
    send_frame(4'hA, 0, 1, 0, 0, 0);
    send_frame(4'h5, 0, 1, 0, 0, 0);
    send_frame(4'h3, 0, 1, 0, 0, 1);
    rdy_mode = 1;
    idle_bits(1);
    // sin_valid is high only every other cycle.
    stall_pct = 100;
    send_frame(4'b1011, 0, 1, 0, 0, 1);
    send_frame(4'b1001, 1, 1, 0, 0, 1);
    stall_pct = 0;
    // The buffer holds a word, and a reset arrives after 2 data bits.
    rdy_mode = 0;
    send_frame(4'h9, 0, 1, 0, 0, 0);
    bit_out(1'b0, 0, 0, 0, 1, '0, 0);
    bit_out(1'b1, 0, 0, 0, 1, '0, 0);
    bit_out(1'b1, 0, 0, 0, 1, '0, 0);
    #2 reset = 1;
    #1;
    chk("midrst_dout", dout, 0);
    chk("midrst_dout_valid", dout_valid, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1 reset = 0;
    m_valid = 0; m_busy = 0; m_dout = '0;
    rdy_mode = 1;
    send_frame(4'hC, 0, 1, 0, 0, 1);
`ifdef SER_RX_PARITY_EN
    send_frame(4'b1011, 0, 1, 0, 0, 1);
    send_frame(4'b1011, 0, 1, 1, 0, 1);
    send_frame(4'b0110, 1, 0, 1, 0, 1);
`endif

    // Randomized frames, with random stalls, ready and errors.
    rdy_mode = 2;
    repeat (60) begin
      stall_pct = $urandom_range(0, 40);
      idle_bits($urandom_range(0, 2));
      send_frame(W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
                 $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), 2);
    end
    stall_pct = 0;
    rdy_mode = 1;
    idle_bits(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
